// File: rtl/seq_divider_pkg.sv
// div_pkg: shared types and helpers for the sequential signed divider.
// Holds the FSM state type, default width, most-negative constant, abs helper.
package div_pkg;

  localparam int DIV_WIDTH = 32;

  localparam logic [DIV_WIDTH-1:0] MIN_NEG =
    {1'b1, {(DIV_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } div_state_t;

  // Magnitude as an unsigned value; MIN_NEG maps to 2^(W-1).
  function automatic logic [DIV_WIDTH-1:0] abs_mag(
    input logic [DIV_WIDTH-1:0] v
  );
    return v[DIV_WIDTH-1] ? -v : v;
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// seq_divider_if: operand/result valid-ready bundle for seq_divider.
// master = requester (in_valid, operands, out_ready); slave = divider.
// SEQ_DIVIDER_UNSIGNED_EN adds op_signed (master -> slave).
interface seq_divider_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             overflow;
`ifdef SEQ_DIVIDER_UNSIGNED_EN
  logic             op_signed;

  modport master (
    output in_valid, dividend, divisor,
    output out_ready, op_signed,
    input  in_ready, out_valid,
    input  quotient, remainder,
    input  div_by_zero, overflow
  );

  modport slave (
    input  in_valid, dividend, divisor,
    input  out_ready, op_signed,
    output in_ready, out_valid,
    output quotient, remainder,
    output div_by_zero, overflow
  );
`else
  modport master (
    output in_valid, dividend, divisor,
    output out_ready,
    input  in_ready, out_valid,
    input  quotient, remainder,
    input  div_by_zero, overflow
  );

  modport slave (
    input  in_valid, dividend, divisor,
    input  out_ready,
    output in_ready, out_valid,
    output quotient, remainder,
    output div_by_zero, overflow
  );
`endif

endinterface

// File: rtl/div_step.sv
// div_step: one combinational restoring shift-subtract iteration.
// In: rem_i, quo_i, dsr_i (divisor magnitude). Out: rem_o, quo_o.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dsr_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0]   sh;
  logic [WIDTH-1:0] trial;
  logic             fits;

  // Shifted remainder needs W+1 bits when the divisor
  // magnitude uses the full W bits; the difference always
  // fits back into W bits when the subtraction succeeds.
  always_comb begin
    sh    = {rem_i, quo_i[WIDTH-1]};
    fits  = sh >= {1'b0, dsr_i};
    trial = sh[WIDTH-1:0] - dsr_i;
    rem_o = fits ? trial : sh[WIDTH-1:0];
    quo_o = {quo_i[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle radix-2 restoring signed divider, 1 bit/clock.
// Ports: clk, rst_n (sync, active-low), bus (seq_divider_if.slave).
// Macro SEQ_DIVIDER_UNSIGNED_EN: bus.op_signed selects signed/unsigned.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input logic          clk,
  input logic          rst_n,
  seq_divider_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;
  logic             rdy_q, rdy_d;

  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             accept;
  logic             is_signed;
  logic             a_neg;
  logic             b_neg;

`ifdef SEQ_DIVIDER_UNSIGNED_EN
  assign is_signed = bus.op_signed;
`else
  assign is_signed = 1'b1;
`endif

  assign accept = rdy_q & bus.in_valid;
  assign a_neg  = is_signed & bus.dividend[WIDTH-1];
  assign b_neg  = is_signed & bus.divisor[WIDTH-1];
  assign a_mag  = a_neg ? abs_mag(bus.dividend)
                        : bus.dividend;
  assign b_mag  = b_neg ? abs_mag(bus.divisor)
                        : bus.divisor;

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dsr_i (dsr_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dsr_d   = dsr_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          qneg_d = a_neg ^ b_neg;
          rneg_d = a_neg;
          dsr_d  = b_mag;
          if (bus.divisor == '0) begin
            quo_d   = '1;
            rem_d   = bus.dividend;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else if (is_signed
                       && bus.dividend == MIN_NEG
                       && bus.divisor == '1) begin
            quo_d   = MIN_NEG;
            rem_d   = '0;
            ovf_d   = 1'b1;
            state_d = DONE;
          end else begin
            quo_d   = a_mag;
            rem_d   = '0;
            cnt_d   = CNT_INIT;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = FIX;
        end
      end
      FIX: begin
        if (qneg_q) quo_d = -quo_q;
        if (rneg_q) rem_d = -rem_q;
        state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          dbz_d   = 1'b0;
          ovf_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Registered so it cannot rise in the cycle a result
    // is consumed.
    rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dsr_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dsr_q   <= dsr_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
      rdy_q   <= rdy_d;
    end
  end

  assign bus.in_ready    = rdy_q;
  assign bus.out_valid   = (state_q == DONE);
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.overflow    = ovf_q;

endmodule
